// File: rtl/tile_match_controller_pkg.sv
// tile_match_controller_pkg: shared state codes, widths and defaults for the tile-matching game
package tile_match_controller_pkg;
  // State codes are shared so the HEX decoder and the mode FSM display agree
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WAIT1 = 4'd1,
    S_RD1   = 4'd2,
    S_LAT1  = 4'd3,
    S_WAIT2 = 4'd4,
    S_RD2   = 4'd5,
    S_LAT2  = 4'd6,
    S_CMP   = 4'd7,
    S_SHOW  = 4'd8,
    S_DONE  = 4'd9
  } state_t;
  localparam int MOVE_W            = 8;
  localparam int DEF_NUM_TILES     = 16;
  localparam int DEF_IDX_W         = 4;
  localparam int DEF_SYM_W         = 3;
  localparam int DEF_REVEAL_CYCLES = 25000000;
  function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
    return v + MOVE_W'(v != '1);
  endfunction
endpackage

// File: rtl/tile_match_controller_if.sv
// tile_match_controller_if: game-round bus between controller, mode FSM, symbol memory and display
//   master (controller): in  ingameOn, select, sel_idx, rd_symbol
//                        out rd_en, rd_addr, tile_up, tile_matched, match_count, move_count, gameOver, state_dbg
//   slave  (environment): the mirror image
interface tile_match_controller_if
  import tile_match_controller_pkg::*;
#(
  parameter int NUM_TILES = DEF_NUM_TILES,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int SYM_W     = DEF_SYM_W
);
  localparam int MC_W = $clog2(NUM_TILES / 2 + 1);
  logic                 ingameOn;
  logic                 select;
  logic [IDX_W-1:0]     sel_idx;
  logic                 rd_en;
  logic [IDX_W-1:0]     rd_addr;
  logic [SYM_W-1:0]     rd_symbol;
  logic [NUM_TILES-1:0] tile_up;
  logic [NUM_TILES-1:0] tile_matched;
  logic [MC_W-1:0]      match_count;
  logic [MOVE_W-1:0]    move_count;
  logic                 gameOver;
  logic [3:0]           state_dbg;
  modport master (
    input  ingameOn, select, sel_idx, rd_symbol,
    output rd_en, rd_addr, tile_up, tile_matched, match_count, move_count, gameOver, state_dbg
  );
  modport slave (
    output ingameOn, select, sel_idx, rd_symbol,
    input  rd_en, rd_addr, tile_up, tile_matched, match_count, move_count, gameOver, state_dbg
  );
endinterface

// File: rtl/tile_match_controller_reveal_timer.sv
// tile_match_controller_reveal_timer: loadable down-counter with zero flag for reveal delays
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_value (priority over counting)
//   i_en       : decrement while nonzero
//   o_zero     : count is zero
module tile_match_controller_reveal_timer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (i_en && r_count != '0) r_count <= r_count - W'(1);
  assign o_zero = r_count == '0;
endmodule

// File: rtl/tile_match_controller.sv
// tile_match_controller: sequences one round of the tile-matching game while ingameOn is high
//   CLOCK_50 : system clock, rising edge
//   resetn   : async active-low reset
//   bus      : master side of tile_match_controller_if (selects, symbol memory read, board state, counters)
module tile_match_controller
  import tile_match_controller_pkg::*;
#(
  parameter int NUM_TILES     = DEF_NUM_TILES,
  parameter int IDX_W         = DEF_IDX_W,
  parameter int SYM_W         = DEF_SYM_W,
  parameter int REVEAL_CYCLES = DEF_REVEAL_CYCLES
) (
  input logic                      CLOCK_50,
  input logic                      resetn,
  tile_match_controller_if.master  bus
);
  localparam int MC_W  = $clog2(NUM_TILES / 2 + 1);
  localparam int TMR_W = $clog2(REVEAL_CYCLES + 1);
  state_t               r_state;
  logic [IDX_W-1:0]     r_idx1, r_idx2, r_rd_addr;
  logic [SYM_W-1:0]     r_sym1, r_sym2;
  logic [NUM_TILES-1:0] r_tile_up, r_tile_matched;
  logic [MC_W-1:0]      r_match_count;
  logic [MOVE_W-1:0]    r_move_count;
  logic                 r_game_over;
  logic [NUM_TILES-1:0] w_up_sh, w_sel_mask, w_m1, w_m2;
  logic [MC_W-1:0]      w_mc_next;
  logic                 w_sel_ok, w_eq, w_done, w_tmr_load, w_tmr_en, w_tmr_zero;
  // Shifting instead of indexing keeps out-of-range sel_idx values harmless
  assign w_up_sh    = r_tile_up >> bus.sel_idx;
  assign w_sel_ok   = bus.select && (32'(bus.sel_idx) < NUM_TILES) && !w_up_sh[0];
  assign w_sel_mask = NUM_TILES'(1) << bus.sel_idx;
  assign w_m1       = NUM_TILES'(1) << r_idx1;
  assign w_m2       = NUM_TILES'(1) << r_idx2;
  assign w_eq       = r_sym1 == r_sym2;
  assign w_mc_next  = r_match_count + MC_W'(1);
  assign w_done     = w_mc_next == MC_W'(NUM_TILES / 2);
  assign w_tmr_load = r_state == S_CMP && !w_eq;
  assign w_tmr_en   = r_state == S_SHOW;
  tile_match_controller_reveal_timer #(.W(TMR_W)) u_timer (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .i_load  (w_tmr_load),
    .i_en    (w_tmr_en),
    .i_value (TMR_W'(REVEAL_CYCLES - 1)),
    .o_zero  (w_tmr_zero)
  );
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_idx1         <= '0;
      r_idx2         <= '0;
      r_rd_addr      <= '0;
      r_sym1         <= '0;
      r_sym2         <= '0;
      r_tile_up      <= '0;
      r_tile_matched <= '0;
      r_match_count  <= '0;
      r_move_count   <= '0;
      r_game_over    <= '0;
    end else if (!bus.ingameOn || r_state == S_IDLE) begin
      // Abort from any state discards the in-flight pair and clears the board
      r_state        <= bus.ingameOn ? S_WAIT1 : S_IDLE;
      r_tile_up      <= '0;
      r_tile_matched <= '0;
      r_match_count  <= '0;
      r_move_count   <= '0;
      r_game_over    <= '0;
    end else begin
      case (r_state)
        S_WAIT1: if (w_sel_ok) begin
          r_idx1    <= bus.sel_idx;
          r_rd_addr <= bus.sel_idx;
          r_tile_up <= r_tile_up | w_sel_mask;
          r_state   <= S_RD1;
        end
        S_RD1: r_state <= S_LAT1;
        S_LAT1: begin
          r_sym1  <= bus.rd_symbol;
          r_state <= S_WAIT2;
        end
        S_WAIT2: if (w_sel_ok) begin
          r_idx2    <= bus.sel_idx;
          r_rd_addr <= bus.sel_idx;
          r_tile_up <= r_tile_up | w_sel_mask;
          r_state   <= S_RD2;
        end
        S_RD2: r_state <= S_LAT2;
        S_LAT2: begin
          r_sym2  <= bus.rd_symbol;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_move_count <= sat_inc(r_move_count);
          if (w_eq) begin
            r_tile_matched <= r_tile_matched | w_m1 | w_m2;
            r_match_count  <= w_mc_next;
            r_state        <= w_done ? S_DONE : S_WAIT1;
            if (w_done) begin
              r_game_over <= 1'b1;
              r_tile_up   <= '1;
            end
          end else r_state <= S_SHOW;
        end
        S_SHOW: if (w_tmr_zero) begin
          r_tile_up <= r_tile_up & ~(w_m1 | w_m2);
          r_state   <= S_WAIT1;
        end
        S_DONE: begin
          r_game_over <= 1'b1;
          r_tile_up   <= '1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.rd_en        = r_state == S_RD1 || r_state == S_RD2;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.tile_up      = r_tile_up;
  assign bus.tile_matched = r_tile_matched;
  assign bus.match_count  = r_match_count;
  assign bus.move_count   = r_move_count;
  assign bus.gameOver     = r_game_over;
  assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_tile_match_controller.sv
// tb_tile_match_controller: directed self-checking bench, 4 tiles, 3-cycle reveal, symbols {5,2,5,2}
module tb_tile_match_controller;
  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int checks   = 0;
  int failures = 0;
  logic [2:0] mem [4] = '{3'd5, 3'd2, 3'd5, 3'd2};
  tile_match_controller_if #(.NUM_TILES(4), .IDX_W(3), .SYM_W(3)) bus ();
  tile_match_controller #(.NUM_TILES(4), .IDX_W(3), .SYM_W(3), .REVEAL_CYCLES(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) if (bus.rd_en) bus.rd_symbol <= mem[bus.rd_addr[1:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask
  task automatic sel(input logic [2:0] idx);
    bus.select  = 1'b1;
    bus.sel_idx = idx;
    tick();
    bus.select  = 1'b0;
  endtask
  task automatic pair(input logic [2:0] a, input logic [2:0] b);
    sel(a);
    tick(2);
    sel(b);
    tick(3);
  endtask
  initial begin
    bus.ingameOn = 1'b0;
    bus.select   = 1'b0;
    bus.sel_idx  = '0;
    tick(2);
    chk("rst_state", bus.state_dbg, 0);
    chk("rst_tile_up", bus.tile_up, 0);
    chk("rst_matched", bus.tile_matched, 0);
    chk("rst_counts", {bus.match_count, bus.move_count, bus.gameOver, bus.rd_en}, 0);
    resetn = 1'b1;
    bus.ingameOn = 1'b1;
    tick();
    chk("idle_to_wait1", bus.state_dbg, 1);
    sel(3'd7);
    chk("ill_range_state", bus.state_dbg, 1);
    chk("ill_range_rden", bus.rd_en, 0);
    sel(3'd0);
    chk("rd1_state", bus.state_dbg, 2);
    chk("rd1_rden_addr", {bus.rd_en, bus.rd_addr}, {1'b1, 3'd0});
    chk("rd1_tile_up", bus.tile_up, 4'b0001);
    tick();
    chk("lat1_rden", {bus.state_dbg, bus.rd_en}, {4'd3, 1'b0});
    tick();
    chk("wait2_state", bus.state_dbg, 4);
    sel(3'd0);
    chk("ill_same_idx", {bus.state_dbg, bus.rd_en}, {4'd4, 1'b0});
    sel(3'd1);
    chk("rd2_rden_addr", {bus.state_dbg, bus.rd_en, bus.rd_addr}, {4'd5, 1'b1, 3'd1});
    chk("rd2_tile_up", bus.tile_up, 4'b0011);
    tick(2);
    chk("cmp_state", bus.state_dbg, 7);
    tick();
    chk("show1", {bus.state_dbg, bus.tile_up}, {4'd8, 4'b0011});
    chk("show_counts", {bus.match_count, bus.move_count}, {2'd0, 8'd1});
    sel(3'd3);
    chk("show2_sel_ignored", {bus.state_dbg, bus.tile_up}, {4'd8, 4'b0011});
    tick();
    chk("show3", {bus.state_dbg, bus.tile_up}, {4'd8, 4'b0011});
    tick();
    chk("show_exit", {bus.state_dbg, bus.tile_up}, {4'd1, 4'b0000});
    pair(3'd0, 3'd2);
    chk("match_state", bus.state_dbg, 1);
    chk("match_bitmap", bus.tile_matched, 4'b0101);
    chk("match_up", bus.tile_up, 4'b0101);
    chk("match_counts", {bus.match_count, bus.move_count}, {2'd1, 8'd2});
    sel(3'd2);
    chk("ill_matched", {bus.state_dbg, bus.rd_en}, {4'd1, 1'b0});
    pair(3'd1, 3'd3);
    chk("done_state", bus.state_dbg, 9);
    chk("done_over", {bus.gameOver, bus.tile_up, bus.tile_matched}, {1'b1, 4'b1111, 4'b1111});
    chk("done_counts", {bus.match_count, bus.move_count}, {2'd2, 8'd3});
    tick();
    chk("done_hold", {bus.state_dbg, bus.gameOver}, {4'd9, 1'b1});
    bus.ingameOn = 1'b0;
    tick(2);
    chk("drop_idle", bus.state_dbg, 0);
    chk("drop_cleared", {bus.tile_up, bus.tile_matched, bus.match_count, bus.move_count, bus.gameOver}, 0);
    bus.ingameOn = 1'b1;
    tick();
    sel(3'd0);
    tick(2);
    sel(3'd1);
    chk("abort_rd2_pre", bus.state_dbg, 5);
    bus.ingameOn = 1'b0;
    tick();
    chk("abort_rd2", bus.state_dbg, 0);
    bus.ingameOn = 1'b1;
    tick();
    chk("fresh_after_rd2", {bus.state_dbg, bus.tile_up, bus.move_count}, {4'd1, 4'b0000, 8'd0});
    pair(3'd0, 3'd1);
    chk("abort_show_pre", bus.state_dbg, 8);
    bus.ingameOn = 1'b0;
    tick();
    chk("abort_show", bus.state_dbg, 0);
    bus.ingameOn = 1'b1;
    tick();
    chk("fresh_after_show", {bus.state_dbg, bus.tile_up, bus.move_count}, {4'd1, 4'b0000, 8'd0});
    sel(3'd2);
    chk("async_pre", bus.state_dbg, 2);
    #3 resetn = 1'b0;
    #1;
    chk("async_state", {bus.state_dbg, bus.rd_en}, 0);
    chk("async_outs", {bus.tile_up, bus.rd_addr, bus.move_count}, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("async_release", bus.state_dbg, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
